// File: rtl/dac_spi_tx.sv
// dac_spi_tx : serialises a sin/cos sample pair into two 16-bit SPI words
// for a dual-channel 12-bit DAC (sin -> channel A, cos -> channel B), then
// pulses LDAC so both DAC outputs update together.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sample_valid single-cycle strobe, sin_in/cos_in valid this cycle
//   sin_in       sine sample   -> DAC channel A
//   cos_in       cosine sample -> DAC channel B
//   overrun_clr  clears the sticky overrun flag
//   busy         high while a frame is in progress
//   frame_done   single-cycle pulse at end of frame
//   overrun      sticky, set when a strobe arrives while busy
//   dac_cs_n     SPI chip select, active low
//   dac_sclk     SPI clock, idle low, DAC samples on rising edges
//   dac_sdi      SPI data, MSB first
//   dac_ldac_n   DAC latch strobe, active low
//   overrun_cnt  (only with DAC_OVERRUN_CNT_EN) saturating drop counter
//
// Build option: define DAC_OVERRUN_CNT_EN to add the 16-bit overrun_cnt port.
//
// Frame timing with D = CLK_DIV, strobe accepted in cycle T:
//   WORD_A T+1 .. T+32D, GAP D cycles, WORD_B 32D cycles, POST D cycles,
//   LDAC D cycles, frame_done at T+1+67D (state already IDLE there).

module dac_spi_tx #(
  parameter int CLK_DIV   = 4,
  parameter int IN_SIGNED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sin_in,
  input  logic [7:0] cos_in,
  input  logic       overrun_clr,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_sdi,
  output logic       dac_ldac_n
`ifdef DAC_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WORD_A = 3'd1,
    GAP    = 3'd2,
    WORD_B = 3'd3,
    POST   = 3'd4,
    LDAC   = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  div_cnt;
  logic [4:0]  half_cnt;
  logic        tick;
  logic        in_word;
  logic        last_half;
  logic        accept;
  logic        drop;
  logic        load_a;
  logic        load_b;
  logic        shift_en;
  logic [15:0] word_a;
  logic [15:0] word_b;
  logic [15:0] shift_p0;
  logic [7:0]  cos_hold_p0;

  logic cs_n_d;
  logic sclk_d;
  logic sdi_d;
  logic ldac_n_d;
  logic busy_d;
  logic frame_done_d;

  // Offset-binary conversion: two's complement maps to offset binary by
  // flipping the sign bit.
  function automatic logic [7:0] conv(input logic [7:0] s);
    if (IN_SIGNED != 0) begin
      conv = {~s[7], s[6:0]};
    end else begin
      conv = s;
    end
  endfunction

  // DAC command word: channel, BUF=0, GA_n=1, SHDN_n=1, 8-bit code
  // left-justified into the 12-bit data field.
  function automatic logic [15:0] build_word(input logic ch, input logic [7:0] s);
    build_word = {ch, 1'b0, 1'b1, 1'b1, conv(s), 4'b0000};
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign in_word   = (state == WORD_A) || (state == WORD_B);
  assign last_half = (half_cnt == 5'd31);
  assign accept    = sample_valid && (state == IDLE);
  assign drop      = sample_valid && (state != IDLE);
  assign word_a    = build_word(1'b0, sin_in);
  assign word_b    = build_word(1'b1, cos_hold_p0);
  assign load_a    = accept;
  assign load_b    = (state == GAP) && tick;
  // Data advances on falling SCLK edges (odd half-period ends), except the
  // very last one, which closes the word instead.
  assign shift_en  = in_word && tick && half_cnt[0] && !last_half;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (sample_valid)      next_state = WORD_A;
      WORD_A:  if (tick && last_half) next_state = GAP;
      GAP:     if (tick)              next_state = WORD_B;
      WORD_B:  if (tick && last_half) next_state = POST;
      POST:    if (tick)              next_state = LDAC;
      LDAC:    if (tick)              next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // Output decode: next values of the registered pins
  always_comb begin
    cs_n_d       = !((next_state == WORD_A) || (next_state == WORD_B));
    ldac_n_d     = (next_state != LDAC);
    busy_d       = (next_state != IDLE);
    frame_done_d = (state == LDAC) && tick;
    sclk_d       = 1'b0;
    if (in_word) begin
      sclk_d = tick ? ~dac_sclk : dac_sclk;
    end
    sdi_d = dac_sdi;
    if (load_a) begin
      sdi_d = word_a[15];
    end else if (load_b) begin
      sdi_d = word_b[15];
    end else if (in_word && tick && last_half) begin
      sdi_d = 1'b0;
    end else if (shift_en) begin
      sdi_d = shift_p0[14];
    end
  end

  // Divider and half-period counters run only inside the frame and restart
  // on every state change, so the first SCLK edge is always D cycles after
  // cs_n falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if ((state != next_state) || (state == IDLE)) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + 5'd1;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  // Stage p0: sample capture and shift register
  always_ff @(posedge clk) begin
    if (load_a) begin
      shift_p0    <= word_a;
      cos_hold_p0 <= cos_in;
    end else if (load_b) begin
      shift_p0    <= word_b;
    end else if (shift_en) begin
      shift_p0    <= {shift_p0[14:0], 1'b0};
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      busy       <= busy_d;
      frame_done <= frame_done_d;
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      dac_sdi    <= sdi_d;
      dac_ldac_n <= ldac_n_d;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef DAC_OVERRUN_CNT_EN
  // Saturating drop counter; a drop together with a clear restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (drop) begin
      if (overrun_clr) begin
        overrun_cnt <= 16'd1;
      end else if (overrun_cnt != 16'hFFFF) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end else if (overrun_clr) begin
      overrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx. Two instances share the stimulus: index 0
// with offset-binary inputs, index 1 with two's complement inputs. The
// stimulus process runs a frame-level reference model and pushes expected
// words and event cycles into queues; per-instance monitors decode the SPI
// pins and pop/compare.
module tb_dac_spi_tx;

  localparam int D = 4;
  localparam int FRAME = 67 * D;

  logic clk;
  logic rst_n;
  logic sample_valid;
  logic [7:0] sin_in;
  logic [7:0] cos_in;
  logic overrun_clr;

  logic [1:0] busy_w, done_w, ovr_w, cs_w, sclk_w, sdi_w, ldac_w;
`ifdef DAC_OVERRUN_CNT_EN
  logic [15:0] cnt_w [2];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] word_q  [2][$];
  int          start_q [2][$];
  int          done_q  [2][$];
  int          ovr_c_q [$];
  logic        ovr_v_q [$];
  int          cnt_v_q [$];

  int  free_cycle = 0;
  bit  ovr_m = 0;
  int  cnt_m = 0;

  dac_spi_tx #(.CLK_DIV(D), .IN_SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sin_in(sin_in), .cos_in(cos_in), .overrun_clr(overrun_clr),
    .busy(busy_w[0]), .frame_done(done_w[0]), .overrun(ovr_w[0]),
    .dac_cs_n(cs_w[0]), .dac_sclk(sclk_w[0]), .dac_sdi(sdi_w[0]),
    .dac_ldac_n(ldac_w[0])
`ifdef DAC_OVERRUN_CNT_EN
    , .overrun_cnt(cnt_w[0])
`endif
  );

  dac_spi_tx #(.CLK_DIV(D), .IN_SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sin_in(sin_in), .cos_in(cos_in), .overrun_clr(overrun_clr),
    .busy(busy_w[1]), .frame_done(done_w[1]), .overrun(ovr_w[1]),
    .dac_cs_n(cs_w[1]), .dac_sclk(sclk_w[1]), .dac_sdi(sdi_w[1]),
    .dac_ldac_n(ldac_w[1])
`ifdef DAC_OVERRUN_CNT_EN
    , .overrun_cnt(cnt_w[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Command word from first principles: channel bit worth 32768, GA_n and
  // SHDN_n worth 8192 + 4096, 8-bit offset-binary code scaled by 16.
  function automatic logic [15:0] exp_word(input int ch, input int s, input int signed_in);
    int code;
    code = (signed_in != 0) ? ((s + 128) % 256) : s;
    return 16'(ch * 32768 + 12288 + code * 16);
  endfunction

  // One stimulus cycle: drive, update the reference model for cycle T=cyc,
  // advance to the next cycle.
  task automatic step(input bit v, input logic [7:0] s, input logic [7:0] c, input bit clr);
    int t;
    bit dropped;
    t = cyc;
    sample_valid = v;
    sin_in = s;
    cos_in = c;
    overrun_clr = clr;
    dropped = v && (t < free_cycle);
    if (v && !dropped) begin
      for (int g = 0; g < 2; g++) begin
        word_q[g].push_back(exp_word(0, int'(s), g));
        word_q[g].push_back(exp_word(1, int'(c), g));
        start_q[g].push_back(t + 1);
        start_q[g].push_back(t + 1 + 33 * D);
        done_q[g].push_back(t + 1 + FRAME);
      end
      free_cycle = t + 1 + FRAME;
    end
    if (dropped) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
    if (dropped && clr) cnt_m = 1;
    else if (dropped) cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
    else if (clr) cnt_m = 0;
    if (v || clr) begin
      ovr_c_q.push_back(t + 1);
      ovr_v_q.push_back(ovr_m);
      cnt_v_q.push_back(cnt_m);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      word_q[g].delete();
      start_q[g].delete();
      done_q[g].delete();
    end
    ovr_c_q.delete();
    ovr_v_q.delete();
    cnt_v_q.delete();
    ovr_m = 1'b0;
    cnt_m = 0;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", busy_w[g], 0);
      chk("rst_frame_done", done_w[g], 0);
      chk("rst_overrun", ovr_w[g], 0);
      chk("rst_cs_n", cs_w[g], 1);
      chk("rst_sclk", sclk_w[g], 0);
      chk("rst_sdi", sdi_w[g], 0);
      chk("rst_ldac_n", ldac_w[g], 1);
`ifdef DAC_OVERRUN_CNT_EN
      chk("rst_overrun_cnt", cnt_w[g], 0);
`endif
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    free_cycle = cyc;
    @(posedge clk); #1;
  endtask

  // Per-instance SPI/LDAC monitor
  for (genvar g = 0; g < 2; g++) begin : mon
    logic        pcs = 1'b1;
    logic        psclk = 1'b0;
    logic        pldac = 1'b1;
    logic [15:0] sh = '0;
    int          nb = 0;
    int          fall_c = 0;
    int          lo_c = 0;
    bit          first = 0;

    always @(negedge clk) begin
      int e;
      if (!rst_n) begin
        nb = 0;
        first = 0;
      end else begin
        if (pcs && !cs_w[g]) begin
          e = (start_q[g].size() != 0) ? start_q[g].pop_front() : -1;
          chk("cs_fall_cycle", cyc, e);
          chk("busy_in_word", busy_w[g], 1);
          nb = 0;
          fall_c = cyc;
          first = 1;
        end
        if (!cs_w[g] && !psclk && sclk_w[g]) begin
          if (first) begin
            chk("first_sclk_delay", cyc - fall_c, D);
            first = 0;
          end
          sh = {sh[14:0], sdi_w[g]};
          nb++;
        end
        if (!pcs && cs_w[g]) begin
          chk("word_bit_count", nb, 16);
          e = (word_q[g].size() != 0) ? int'(word_q[g].pop_front()) : -1;
          chk("spi_word", {16'h0, sh}, e);
          chk("cs_high_len", cyc - fall_c, 32 * D);
          chk("sdi_after_word", sdi_w[g], 0);
        end
        if (pldac && !ldac_w[g]) lo_c = cyc;
        if (!pldac && ldac_w[g]) chk("ldac_low_len", cyc - lo_c, D);
        if (done_w[g]) begin
          e = (done_q[g].size() != 0) ? done_q[g].pop_front() : -1;
          chk("frame_done_cycle", cyc, e);
          chk("busy_at_done", busy_w[g], 0);
          chk("ldac_at_done", ldac_w[g], 1);
        end
      end
      pcs = cs_w[g];
      psclk = sclk_w[g];
      pldac = ldac_w[g];
    end
  end

  // Overrun flag / counter monitor
  always @(negedge clk) begin
    int c;
    logic v;
    int n;
    if (rst_n) begin
      while (ovr_c_q.size() != 0 && ovr_c_q[0] <= cyc) begin
        c = ovr_c_q.pop_front();
        v = ovr_v_q.pop_front();
        n = cnt_v_q.pop_front();
        chk("overrun_event_cycle", c, cyc);
        for (int g = 0; g < 2; g++) begin
          chk("overrun", ovr_w[g], v);
`ifdef DAC_OVERRUN_CNT_EN
          chk("overrun_cnt", cnt_w[g], n);
`endif
        end
      end
    end
  end

  initial begin
    int viol;
    int t0;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sin_in = '0;
    cos_in = '0;
    overrun_clr = 1'b0;

    do_reset();

    // quiet idle after reset
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0);
      for (int g = 0; g < 2; g++)
        if (sclk_w[g] || !cs_w[g] || !ldac_w[g] || busy_w[g]) viol++;
    end
    chk("idle_activity", viol, 0);

    // directed patterns
    step(1'b1, 8'h00, 8'h80, 1'b0);
    idle(FRAME + 20);
    step(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(FRAME + 20);

    // drops, clear, drop+clear, three counted drops
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    idle(9);
    step(1'b1, 8'h55, 8'hAA, 1'b0);
    idle(5);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    idle(3);
    step(1'b1, 8'h11, 8'h22, 1'b1);
    idle(3);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      idle(4);
    end
    idle(FRAME);

    // back-to-back: strobe exactly in the frame_done cycle
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    while (cyc < free_cycle) step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    while (cyc < free_cycle) step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    idle(FRAME + 10);

    // reset in the middle of WORD_B, then a full frame
    t0 = cyc;
    step(1'b1, 8'h3C, 8'hC3, 1'b0);
    while (cyc < t0 + 1 + 33 * D + 40) step(1'b0, 8'h00, 8'h00, 1'b0);
    do_reset();
    idle(5);
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    idle(FRAME + 10);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 40) == 0, 8'($urandom), 8'($urandom), ($urandom % 25) == 0);

    // drain outstanding frames
    for (int i = 0; i < FRAME + 20; i++) begin
      if (done_q[0].size() == 0 && done_q[1].size() == 0) break;
      idle(1);
    end
    idle(5);
    for (int g = 0; g < 2; g++) begin
      chk("pending_frames", done_q[g].size(), 0);
      chk("pending_words", word_q[g].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
